rx_slot_ctrl: RTL and testbench

PCI-clock-domain controller for the single Ethernet RX frame slot. It takes ownership of the slot when the GMII receiver reports a completed frame and presents a descriptor (length, timestamp) to the host side. It arbitrates the slot RAM read port between a host PIO reader and a DMA reader, and returns the slot to the receiver when the consumer releases it. It also drives the receiver's `rx_empty` handshake and keeps frame/overrun statistics.

---
 rtl/ethpipe_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/rx_slot_ctrl.sv | 107 ++++++++++
 tb/tb_rx_slot_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethpipe_pkg.sv
// rtl/ethpipe_pkg.sv - shared types and defaults for the RX frame slot controller
package ethpipe_pkg;

    localparam int ADDR_W_DEF  = 11;
    localparam int DATA_W_DEF  = 32;
    localparam int FRAME_LEN_W = 12;

    typedef logic [FRAME_LEN_W-1:0] frame_len_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_BUSY  = 2'd2
    } slot_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter for the slot RAM read port
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pio_req,
    input  logic dma_req,
    output logic pio_gnt,
    output logic dma_gnt
);

    // Set when DMA won most recently; reset there so PIO takes the first tie.
    logic last_dma;

    always_comb begin
        pio_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (en) begin
            if (pio_req && dma_req) begin
                pio_gnt = last_dma;
                dma_gnt = !last_dma;
            end else begin
                pio_gnt = pio_req;
                dma_gnt = dma_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dma <= 1'b1;
        end else if (pio_gnt) begin
            last_dma <= 1'b0;
        end else if (dma_gnt) begin
            last_dma <= 1'b1;
        end
    end

endmodule

// File: rtl/rx_slot_ctrl.sv
// rtl/rx_slot_ctrl.sv - RX slot ownership FSM, descriptor capture, read arbitration and stats
module rx_slot_ctrl
    import ethpipe_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              pci_clk,
    input  logic              sys_rst,
    input  logic              rx_complete,
    input  frame_len_t        rx_frame_len,
    input  logic [63:0]       rx_timestamp,
    output logic              rx_empty,
    output logic              desc_valid,
    input  logic              desc_ready,
    output frame_len_t        desc_len,
    output logic [63:0]       desc_ts,
    input  logic              slot_release,
    input  logic              pio_req,
    input  logic [ADDR_W-1:0] pio_addr,
    output logic              pio_gnt,
    output logic              pio_rvalid,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] slot_rd_address,
    input  logic [DATA_W-1:0] slot_rd_q,
    output logic [31:0]       stat_frames,
    output logic [15:0]       stat_overrun
);

    slot_state_t state, state_next;
    logic        arb_en;
    logic        capture;
    logic        overrun_hit;
    logic [1:0]  tag_s1, tag_s2;

    always_comb begin
        state_next  = state;
        desc_valid  = (state == S_FULL);
        arb_en      = (state != S_EMPTY);
        capture     = (state == S_EMPTY) && rx_complete;
        overrun_hit = (state != S_EMPTY) && rx_complete;
        case (state)
            S_EMPTY: if (rx_complete)  state_next = S_FULL;
            S_FULL:  if (desc_ready)   state_next = S_BUSY;
            S_BUSY:  if (slot_release) state_next = S_EMPTY;
            default:                   state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge pci_clk) begin
        if (sys_rst) begin
            state        <= S_EMPTY;
            rx_empty     <= 1'b1;
            desc_len     <= '0;
            desc_ts      <= '0;
            stat_frames  <= '0;
            stat_overrun <= '0;
        end else begin
            state    <= state_next;
            rx_empty <= (state_next == S_EMPTY);
            if (capture) begin
                desc_len    <= rx_frame_len;
                desc_ts     <= rx_timestamp;
                stat_frames <= stat_frames + 32'd1;
            end
            if (overrun_hit) begin
                stat_overrun <= sat_inc16(stat_overrun);
            end
        end
    end

    rr_arb2 u_arb (
        .clk     (pci_clk),
        .rst     (sys_rst),
        .en      (arb_en),
        .pio_req (pio_req),
        .dma_req (dma_req),
        .pio_gnt (pio_gnt),
        .dma_gnt (dma_gnt)
    );

    // Owner tag rides two stages to line up with the RAM's registered output.
    always_ff @(posedge pci_clk) begin
        if (sys_rst) begin
            slot_rd_address <= '0;
            tag_s1          <= 2'b00;
            tag_s2          <= 2'b00;
        end else begin
            if (pio_gnt) begin
                slot_rd_address <= pio_addr;
            end else if (dma_gnt) begin
                slot_rd_address <= dma_addr;
            end
            tag_s1 <= {pio_gnt, dma_gnt};
            tag_s2 <= tag_s1;
        end
    end

    assign pio_rvalid = tag_s2[1];
    assign dma_rvalid = tag_s2[0];
    assign rd_data    = (|tag_s2) ? slot_rd_q : '0;

endmodule

// File: tb/tb_rx_slot_ctrl.sv
// tb/tb_rx_slot_ctrl.sv - randomized self-checking bench for rx_slot_ctrl
module tb_rx_slot_ctrl;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int M_EMPTY = 0;
    localparam int M_FULL  = 1;
    localparam int M_BUSY  = 2;

    logic              pci_clk = 1'b0;
    logic              sys_rst;
    logic              rx_complete;
    logic [11:0]       rx_frame_len;
    logic [63:0]       rx_timestamp;
    logic              rx_empty;
    logic              desc_valid;
    logic              desc_ready;
    logic [11:0]       desc_len;
    logic [63:0]       desc_ts;
    logic              slot_release;
    logic              pio_req, dma_req;
    logic [ADDR_W-1:0] pio_addr, dma_addr;
    logic              pio_gnt, dma_gnt;
    logic              pio_rvalid, dma_rvalid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] slot_rd_address;
    logic [DATA_W-1:0] slot_rd_q;
    logic [31:0]       stat_frames;
    logic [15:0]       stat_overrun;

    rx_slot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .pci_clk         (pci_clk),
        .sys_rst         (sys_rst),
        .rx_complete     (rx_complete),
        .rx_frame_len    (rx_frame_len),
        .rx_timestamp    (rx_timestamp),
        .rx_empty        (rx_empty),
        .desc_valid      (desc_valid),
        .desc_ready      (desc_ready),
        .desc_len        (desc_len),
        .desc_ts         (desc_ts),
        .slot_release    (slot_release),
        .pio_req         (pio_req),
        .pio_addr        (pio_addr),
        .pio_gnt         (pio_gnt),
        .pio_rvalid      (pio_rvalid),
        .dma_req         (dma_req),
        .dma_addr        (dma_addr),
        .dma_gnt         (dma_gnt),
        .dma_rvalid      (dma_rvalid),
        .rd_data         (rd_data),
        .slot_rd_address (slot_rd_address),
        .slot_rd_q       (slot_rd_q),
        .stat_frames     (stat_frames),
        .stat_overrun    (stat_overrun)
    );

    always #5 pci_clk = ~pci_clk;

    // Slot RAM: word n holds n, 1-cycle registered read
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = i;
    always @(posedge pci_clk) slot_rd_q <= mem[slot_rd_address];

    typedef struct {
        int due;
        bit is_pio;
        int addr;
    } rd_t;

    rd_t         pend[$];
    int          m_state;
    logic [11:0] m_len;
    logic [63:0] m_ts;
    logic [31:0] m_frames;
    int          m_overrun;
    bit          m_last_pio;
    int          m_addr;
    bit          m_addr_chk;
    int          cyc;
    int          n_checks;
    int          n_errors;
    bit          checking;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic exp_gnt(output bit gp, output bit gd);
        gp = 1'b0;
        gd = 1'b0;
        if (m_state != M_EMPTY) begin
            if (pio_req && dma_req) begin
                gp = !m_last_pio;
                gd = m_last_pio;
            end else begin
                gp = pio_req;
                gd = dma_req;
            end
        end
    endtask

    task automatic check_all();
        bit gp, gd, ev_p, ev_d;
        logic [DATA_W-1:0] ed;
        exp_gnt(gp, gd);
        ev_p = 1'b0;
        ev_d = 1'b0;
        ed   = '0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                if (pend[i].is_pio) ev_p = 1'b1;
                else                ev_d = 1'b1;
                ed = mem[pend[i].addr];
            end
        end
        check_val("rx_empty", rx_empty, m_state == M_EMPTY);
        check_val("desc_valid", desc_valid, m_state == M_FULL);
        check_val("desc_len", desc_len, m_len);
        check_val("desc_ts", desc_ts, m_ts);
        check_val("stat_frames", stat_frames, m_frames);
        check_val("stat_overrun", stat_overrun, m_overrun);
        check_val("pio_gnt", pio_gnt, gp);
        check_val("dma_gnt", dma_gnt, gd);
        check_val("pio_rvalid", pio_rvalid, ev_p);
        check_val("dma_rvalid", dma_rvalid, ev_d);
        if (ev_p || ev_d) check_val("rd_data", rd_data, ed);
        if (m_addr_chk) check_val("slot_rd_address", slot_rd_address, m_addr);
    endtask

    task automatic model_update();
        bit gp, gd;
        rd_t e;
        if (sys_rst) begin
            m_state    = M_EMPTY;
            m_len      = '0;
            m_ts       = '0;
            m_frames   = '0;
            m_overrun  = 0;
            m_last_pio = 1'b0;
            m_addr     = 0;
            m_addr_chk = 1'b1;
            pend.delete();
            return;
        end
        exp_gnt(gp, gd);
        if (gp || gd) begin
            e.due    = cyc + 2;
            e.is_pio = gp;
            e.addr   = gp ? int'(pio_addr) : int'(dma_addr);
            pend.push_back(e);
            m_addr     = e.addr;
            m_addr_chk = 1'b1;
            m_last_pio = gp;
        end else begin
            m_addr_chk = 1'b0;
        end
        if (rx_complete && m_state != M_EMPTY && m_overrun < 65535) m_overrun++;
        case (m_state)
            M_EMPTY: if (rx_complete) begin
                m_state  = M_FULL;
                m_len    = rx_frame_len;
                m_ts     = rx_timestamp;
                m_frames = m_frames + 1;
            end
            M_FULL:  if (desc_ready)   m_state = M_BUSY;
            default: if (slot_release) m_state = M_EMPTY;
        endcase
    endtask

    task automatic cycle();
        #4;
        if (checking) check_all();
        @(posedge pci_clk);
        model_update();
        cyc++;
        while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        checking = 1'b0;
        sys_rst = 1'b1; rx_complete = 1'b0; rx_frame_len = '0; rx_timestamp = '0;
        desc_ready = 1'b0; slot_release = 1'b0;
        pio_req = 1'b0; dma_req = 1'b0; pio_addr = '0; dma_addr = '0;
        cycle();
        cycle();
        sys_rst  = 1'b0;
        checking = 1'b1;
        cycle();

        rx_complete = 1'b1; rx_frame_len = 12'd60; rx_timestamp = 64'h1234;
        cycle();
        rx_complete = 1'b0;
        slot_release = 1'b1;
        cycle();
        slot_release = 1'b0;

        for (int i = 0; i < 4; i++) begin
            pio_req = 1'b1; pio_addr = ADDR_W'(i);
            cycle();
        end
        pio_req = 1'b0;
        cycle(); cycle();

        rx_complete = 1'b1; rx_frame_len = 12'd100; rx_timestamp = 64'h99;
        cycle();
        rx_complete = 1'b0;
        desc_ready = 1'b1;
        cycle();
        desc_ready = 1'b0;

        pio_req = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pio_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            dma_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            cycle();
        end
        pio_req = 1'b0; dma_req = 1'b0;
        cycle(); cycle();

        rx_complete = 1'b1; slot_release = 1'b1;
        cycle();
        rx_complete = 1'b0; slot_release = 1'b0;
        cycle();

        pio_req = 1'b1; dma_req = 1'b1;
        cycle(); cycle(); cycle();
        pio_req = 1'b0; dma_req = 1'b0;

        rx_complete = 1'b1; rx_frame_len = 12'd7; rx_timestamp = 64'hABCD;
        cycle();
        rx_complete = 1'b0;
        pio_req = 1'b1; pio_addr = 11'd5;
        cycle();
        pio_req = 1'b0; sys_rst = 1'b1;
        cycle();
        sys_rst = 1'b0;
        cycle(); cycle(); cycle();

        for (int i = 0; i < 3000; i++) begin
            sys_rst      = ($urandom_range(0, 199) == 0);
            rx_complete  = ($urandom_range(0, 7) == 0);
            rx_frame_len = 12'($urandom());
            rx_timestamp = {$urandom(), $urandom()};
            desc_ready   = ($urandom_range(0, 2) == 0);
            slot_release = ($urandom_range(0, 5) == 0);
            pio_req      = $urandom_range(0, 1) == 1;
            dma_req      = $urandom_range(0, 1) == 1;
            pio_addr     = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            dma_addr     = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            cycle();
        end
        sys_rst = 1'b0; rx_complete = 1'b0; desc_ready = 1'b0; slot_release = 1'b0;
        pio_req = 1'b0; dma_req = 1'b0;
        cycle(); cycle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
